// File: rtl/md_pkg.sv
// Shared definitions for the MULDIV issue controller: instruction encodings,
// MULDIV op codes and the issue FSM states.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MFHI  = 3'd6;
    localparam logic [2:0] MD_MFLO  = 3'd7;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4
    } md_state_e;

endpackage

// File: rtl/md_op_decode.sv
// Combinational classification of the EX-stage MD instruction opcode.
module md_op_decode
    import md_pkg::*;
(
    input  logic [2:0] in_op_i,
    output logic       is_muldiv_o,
    output logic       is_mt_o,
    output logic       is_mf_o,
    output logic [1:0] md_op_o,
    output logic       hilo_o
);

    assign is_muldiv_o = (in_op_i == MD_MULT) | (in_op_i == MD_MULTU) |
                         (in_op_i == MD_DIV)  | (in_op_i == MD_DIVU);
    assign is_mt_o     = (in_op_i == MD_MTHI) | (in_op_i == MD_MTLO);
    assign is_mf_o     = (in_op_i == MD_MFHI) | (in_op_i == MD_MFLO);
    assign md_op_o     = in_op_i[1:0];
    // Meaningful only for move instructions: HI for MTHI/MFHI, LO otherwise.
    assign hilo_o      = (in_op_i == MD_MTHI) | (in_op_i == MD_MFHI);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues MULT/DIV and HI/LO moves from EX to the MULDIV unit, stalling EX while busy.
// Optional build macro MD_FLUSH_EN adds a flush input that cancels pending strobes.
module md_issue_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        in_ready,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_we,
    output logic        md_hilo,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        rd_valid,
    output logic [31:0] rd_data
);

    logic flush_w;
`ifdef MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    md_state_e   state_q, state_d;
    logic [1:0]  md_op_q;
    logic [31:0] d1_q, d2_q;
    logic        hilo_q;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;

    logic        is_muldiv, is_mt, is_mf, dec_hilo;
    logic [1:0]  dec_op;
    logic        accept;

    md_op_decode u_decode (
        .in_op_i     (in_op),
        .is_muldiv_o (is_muldiv),
        .is_mt_o     (is_mt),
        .is_mf_o     (is_mf),
        .md_op_o     (dec_op),
        .hilo_o      (dec_hilo)
    );

    assign in_ready = (state_q == ST_IDLE) & ~reset & ~flush_w;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_muldiv)
                    state_d = ST_START;
                else if (accept && is_mt)
                    state_d = ST_WRITE;
            end
            ST_START: state_d = flush_w ? ST_IDLE : ST_ARM;
            // MULDIV sees the start only now, so busy is first meaningful here.
            ST_ARM:   state_d = md_busy ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_d = md_busy ? ST_WAIT : ST_IDLE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            md_op_q    <= MDU_MULT;
            d1_q       <= 32'd0;
            d2_q       <= 32'd0;
            hilo_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= accept & is_mf;
            if (accept && is_mf)
                rd_data_q <= dec_hilo ? md_hi : md_lo;
            if (accept && is_muldiv) begin
                md_op_q <= dec_op;
                d1_q    <= in_rs;
                d2_q    <= in_rt;
            end
            if (accept && is_mt) begin
                d1_q   <= in_rs;
                hilo_q <= dec_hilo;
            end
        end
    end

    // Strobes are gated combinationally so a flush cancels them in the same cycle.
    assign md_start = (state_q == ST_START) & ~flush_w;
    assign md_we    = (state_q == ST_WRITE) & ~flush_w;
    assign rd_valid = rd_valid_q & ~flush_w;
    assign rd_data  = rd_data_q;
    assign md_op    = md_op_q;
    assign md_d1    = d1_q;
    assign md_d2    = d2_q;
    assign md_hilo  = hilo_q;

endmodule
